// File: rtl/clarvi_button_scanner.sv
// clarvi_button_scanner
//   Autonomous poller for the Buttons PIO. An Avalon-MM master reads the PIO
//   data word every PERIOD cycles. Each accepted sample is compared with the
//   previous one, and any rising edges are latched into a sticky EDGE
//   register. irq is raised while any masked EDGE bit is set.
//
//   Optional build macro: BUTTON_SCANNER_DEBOUNCE_EN. When it is defined, a
//   new sample is accepted only after DEBOUNCE_CNT consecutive identical polls.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   avs_*                 CPU slave: 0 STATE (RO), 1 PERIOD, 2 MASK, 3 EDGE (W1C)
//                         readdata registered, read latency 1, 0 when not reading
//   avm_*                 master port towards the PIO data register (PIO_ADDR)
//   irq                   registered level interrupt, |(EDGE & MASK)
module clarvi_button_scanner #(
  parameter int          DATA_W       = 24,
  parameter int          PERIOD_W     = 24,
  parameter int          PERIOD_RST   = 50000,
  parameter logic [31:0] PIO_ADDR     = 32'h0,
  parameter int          DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        irq
);

  localparam logic [PERIOD_W-1:0] PERIOD_INIT = PERIOD_W'(PERIOD_RST);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_UPDATE} fsm_e;

  fsm_e                fsm_q, fsm_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [DATA_W-1:0]   state_q, state_d;
  logic [DATA_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic                primed_q, primed_d;
  logic                irq_q, irq_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                accept;
  logic [DATA_W-1:0]   new_val;
  logic [DATA_W-1:0]   edge_set;
  logic [DATA_W-1:0]   edge_clr;

  assign avm_address  = PIO_ADDR;
  assign avm_read     = (fsm_q == S_REQ);
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

  // Poll sequencer. The counter runs only in IDLE, so the poll interval is
  // PERIOD plus the bus latency of the read, and requests cannot overlap.
  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    case (fsm_q)
      S_IDLE: begin
        if (period_q == '0) begin
          cnt_d = '0;
        end else if (cnt_q >= period_q - 1'b1) begin
          cnt_d = '0;
          fsm_d = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        if (!avm_waitrequest) fsm_d = S_WAIT;
      end
      S_WAIT: begin
        if (avm_readdatavalid) begin
          sample_d = avm_readdata[DATA_W-1:0];
          fsm_d    = S_UPDATE;
        end
      end
      S_UPDATE: fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

`ifdef BUTTON_SCANNER_DEBOUNCE_EN
  localparam int SW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_CNT);

  logic [DATA_W-1:0] cand_q, cand_d;
  logic [SW-1:0]     stable_q, stable_d;

  // A change is accepted only in the UPDATE where the candidate has been
  // seen DEBOUNCE_CNT times in a row; the saturated count keeps it quiet
  // afterwards because STATE then equals the candidate.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    accept   = 1'b0;
    if (fsm_q == S_UPDATE) begin
      if (sample_q != cand_q) begin
        cand_d   = sample_q;
        stable_d = SW'(1);
      end else if (stable_q != STABLE_MAX) begin
        stable_d = stable_q + 1'b1;
      end
      accept = (stable_d == STABLE_MAX) && (!primed_q || (cand_d != state_q));
    end
    new_val = cand_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand_q   <= '0;
      stable_q <= '0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{avs_writedata, avm_readdata};
`else
  always_comb begin
    accept  = (fsm_q == S_UPDATE);
    new_val = sample_q;
  end

  logic unused_ok;
  assign unused_ok = ^{avs_writedata, avm_readdata, 1'(DEBOUNCE_CNT)};
`endif

  // Accept, register writes and readback.
  always_comb begin
    state_d  = state_q;
    primed_d = primed_q;
    period_d = period_q;
    mask_d   = mask_q;
    edge_set = '0;
    edge_clr = '0;
    rdata_d  = 32'h0;

    // The first accepted sample only primes STATE; it has no history to
    // compare against.
    if (accept) begin
      if (primed_q) edge_set = new_val & ~state_q;
      state_d  = new_val;
      primed_d = 1'b1;
    end

    if (avs_write) begin
      case (avs_address)
        2'd1:    period_d = avs_writedata[PERIOD_W-1:0];
        2'd2:    mask_d   = avs_writedata[DATA_W-1:0];
        2'd3:    edge_clr = avs_writedata[DATA_W-1:0];
        default: ;
      endcase
    end

    if (avs_read) begin
      case (avs_address)
        2'd0:    rdata_d = 32'(state_q);
        2'd1:    rdata_d = 32'(period_q);
        2'd2:    rdata_d = 32'(mask_q);
        default: rdata_d = 32'(edge_q);
      endcase
    end

    // A new edge beats a simultaneous W1C so that no press is lost.
    edge_d = (edge_q & ~edge_clr) | edge_set;
    irq_d  = |(edge_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q    <= S_IDLE;
      cnt_q    <= '0;
      period_q <= PERIOD_INIT;
      sample_q <= '0;
      state_q  <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      primed_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      sample_q <= sample_d;
      state_q  <= state_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      primed_q <= primed_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
